hgcal_input_quantizer: RTL and testbench

Upstream stage of the HGCAL autoencoder LogicNets datapath: accepts calibrated sensor-cell samples one per cycle on a valid/ready stream, quantizes each to a 2-bit code, and assembles a full input frame. The completed frame is presented as one wide registered vector with valid/ready to the layer-0 neuron LUTs, which slice their 8-bit fan-in (four 2-bit features) directly from it. A two-buffer arrangement (fill buffer plus output register) lets the next frame stream in while the current one is held.

---
 rtl/hgcal_input_pkg.sv | 23 ++
 rtl/hgcal_sample_quant.sv | 18 +
 rtl/hgcal_input_quantizer.sv | 131 +++++++++++++
 tb/tb_hgcal_input_quantizer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hgcal_input_pkg.sv
// Shared types and helpers for the HGCAL input quantizer: FSM states,
// code width/limit and the sample-to-code function.
package hgcal_input_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam int unsigned    Q_W   = 2;
  localparam logic [Q_W-1:0] Q_MAX = 2'd3;

  // Widened to 32 bits so the add can never overflow for any legal IN_W.
  function automatic logic [Q_W-1:0] quant_code(input logic [31:0]   sample,
                                                input logic [31:0]   r,
                                                input int unsigned   shift);
    logic [31:0] q;
    q = (sample + r) >> shift;
    return (q > 32'(Q_MAX)) ? Q_MAX : q[Q_W-1:0];
  endfunction

endpackage

// File: rtl/hgcal_sample_quant.sv
// Combinational sample quantizer: optional half-LSB rounding, right shift,
// then saturation to the largest 2-bit code.
module hgcal_sample_quant
  import hgcal_input_pkg::*;
#(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned SHIFT = 6
) (
  input  logic [IN_W-1:0] data,
  input  logic            round_en,
  output logic [Q_W-1:0]  code
);

  localparam logic [31:0] HALF = 32'd1 << (SHIFT - 1);

  assign code = quant_code(32'(data), round_en ? HALF : 32'd0, SHIFT);

endmodule

// File: rtl/hgcal_input_quantizer.sv
// Frame assembler for the HGCAL autoencoder inputs: quantizes a sample stream
// into a fill buffer and hands complete frames to a registered output vector.
// Define HGCAL_INPUT_ROUNDING_EN to round half up instead of truncating.
module hgcal_input_quantizer
  import hgcal_input_pkg::*;
#(
  parameter int unsigned N_INPUTS = 48,
  parameter int unsigned IN_W     = 8,
  parameter int unsigned SHIFT    = 6,
  parameter int unsigned FCNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [IN_W-1:0]           s_data,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [Q_W*N_INPUTS-1:0]   m_data,
  output logic                      err,
  output logic [FCNT_W-1:0]         frame_cnt
);

  localparam int unsigned      IDX_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

`ifdef HGCAL_INPUT_ROUNDING_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  state_t                    state, state_d;
  logic [IDX_W-1:0]          idx;
  logic [Q_W*N_INPUTS-1:0]   fill;
  logic [Q_W-1:0]            code;
  logic                      accept, at_end, transfer, drain;
  logic                      wr_en, idx_clr, idx_inc, err_d;

  hgcal_sample_quant #(
    .IN_W  (IN_W),
    .SHIFT (SHIFT)
  ) u_quant (
    .data     (s_data),
    .round_en (ROUND_EN),
    .code     (code)
  );

  assign accept   = s_valid && s_ready;
  assign at_end   = (idx == LAST_IDX);
  assign drain    = m_valid && m_ready;
  assign transfer = (state == HOLD) && (!m_valid || m_ready);

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state;
    wr_en   = 1'b0;
    idx_clr = 1'b0;
    idx_inc = 1'b0;
    err_d   = 1'b0;
    unique case (state)
      FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (!at_end) begin
            if (s_last) begin
              err_d   = 1'b1;
              idx_clr = 1'b1;
            end else begin
              idx_inc = 1'b1;
            end
          end else if (s_last) begin
            state_d = HOLD;
          end else begin
            err_d   = 1'b1;
            state_d = DROP;
          end
        end
      end
      HOLD: begin
        if (transfer) begin
          idx_clr = 1'b1;
          state_d = FILL;
        end
      end
      DROP: begin
        if (accept && s_last) begin
          idx_clr = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      idx       <= '0;
      s_ready   <= 1'b0;
      err       <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      frame_cnt <= '0;
    end else begin
      state   <= state_d;
      s_ready <= (state_d != HOLD);
      err     <= err_d;
      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + IDX_W'(1);
      if (transfer) begin
        m_valid <= 1'b1;
        m_data  <= fill;
      end else if (drain) begin
        m_valid <= 1'b0;
      end
      if (drain) frame_cnt <= frame_cnt + FCNT_W'(1);
    end
  end

  // NOTE: the fill buffer has no reset; a frame only reaches m_data after all
  // of its entries were rewritten, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (wr_en) fill[idx*Q_W +: Q_W] <= code;
  end

endmodule

// File: tb/tb_hgcal_input_quantizer.sv
// Directed self-checking bench for hgcal_input_quantizer at default parameters.
// Expected codes follow HGCAL_INPUT_ROUNDING_EN when the bench is built with it.
module tb_hgcal_input_quantizer;

  localparam int N = 48;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [2*N-1:0] m_data;
  logic          err;
  logic [15:0]   frame_cnt;

  int tests = 0;
  int fails = 0;
  int err_cnt = 0;

  logic [7:0]     vec [N];
  logic [2*N-1:0] exp_nom;
  logic [2*N-1:0] exp_sat;

  hgcal_input_quantizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .err       (err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (err === 1'b1) err_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    s_valid = 1'b0;
    s_last  = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Present one sample and return #1 after the edge that accepted it.
  task automatic push(input logic [7:0] d, input logic last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (s_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL push_timeout: s_ready=%b after %0d cycles, required 1", s_ready, n);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic load_nominal();
    for (int k = 0; k < N; k++) vec[k] = 8'(64 * (k % 4));
  endtask

  task automatic send_frame(input int n, input int last_at);
    for (int k = 0; k < n; k++) push((k < N) ? vec[k] : 8'hFF, k == last_at);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++; if (s_ready !== 1'b0)  begin fails++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
    tests++; if (m_valid !== 1'b0)  begin fails++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    tests++; if (m_data !== '0)     begin fails++; $display("FAIL rst_m_data: got %h want 0", m_data); end
    tests++; if (err !== 1'b0)      begin fails++; $display("FAIL rst_err: got %b want 0", err); end
    tests++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (s_ready !== 1'b1)  begin fails++; $display("FAIL rst_release_s_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_quant_sweep();
    logic [7:0] sw_in  [7];
    logic [1:0] sw_exp [7];
    sw_in = '{8'd0, 8'd31, 8'd32, 8'd63, 8'd64, 8'd200, 8'd255};
`ifdef HGCAL_INPUT_ROUNDING_EN
    sw_exp = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3};
`else
    sw_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd3, 2'd3};
`endif
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < N; k++) vec[k] = (k < 7) ? sw_in[k] : 8'd0;
    send_frame(N, N - 1);
    @(posedge clk); #1;
    for (int k = 0; k < 7; k++) begin
      tests++;
      if (m_data[2*k +: 2] !== sw_exp[k]) begin
        fails++;
        $display("FAIL quant_%0d: code %0d for sample %0d, want %0d", k, m_data[2*k +: 2], sw_in[k], sw_exp[k]);
      end
    end
  endtask

  task automatic test_nominal();
    do_reset();
    m_ready = 1'b1;
    load_nominal();
    send_frame(N, N - 1);
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL nom_early_valid: got %b want 0 at t+1", m_valid); end
    @(posedge clk); #1;
    tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL nom_valid: got %b want 1 at t+2", m_valid); end
    tests++; if (m_data !== exp_nom) begin fails++; $display("FAIL nom_data: got %h want %h", m_data, exp_nom); end
    tests++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL nom_cnt_before: got %0d want 0", frame_cnt); end
    @(posedge clk); #1;
    tests++; if (frame_cnt !== 16'd1) begin fails++; $display("FAIL nom_cnt_after: got %0d want 1", frame_cnt); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL nom_drained: got %b want 0", m_valid); end
  endtask

  task automatic test_back_to_back();
    time t1, t2;
    do_reset();
    m_ready = 1'b1;
    load_nominal();
    send_frame(N, N - 1);
    t1 = $time;
    send_frame(N, N - 1);
    t2 = $time;
    tests++;
    if ((t2 - t1) != 49 * 10) begin
      fails++;
      $display("FAIL b2b_period: %0d cycles between last accepts, want 49", (t2 - t1) / 10);
    end
    repeat (2) @(posedge clk);
    #1;
    tests++; if (frame_cnt !== 16'd2) begin fails++; $display("FAIL b2b_cnt: got %0d want 2", frame_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    m_ready = 1'b0;
    load_nominal();
    send_frame(N, N - 1);
    for (int k = 0; k < N; k++) vec[k] = 8'hFF;
    send_frame(N, N - 1);
    repeat (3) @(posedge clk);
    #1;
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL bp_s_ready: got %b want 0 in HOLD", s_ready); end
    tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL bp_m_valid: got %b want 1", m_valid); end
    tests++; if (m_data !== exp_nom) begin fails++; $display("FAIL bp_held_data: got %h want %h", m_data, exp_nom); end
    tests++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL bp_cnt_held: got %0d want 0", frame_cnt); end
    m_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (m_data !== exp_sat) begin fails++; $display("FAIL bp_swap_data: got %h want %h", m_data, exp_sat); end
    tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL bp_swap_valid: got %b want 1", m_valid); end
    tests++; if (frame_cnt !== 16'd1) begin fails++; $display("FAIL bp_swap_cnt: got %0d want 1", frame_cnt); end
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL bp_s_ready_back: got %b want 1", s_ready); end
    @(posedge clk); #1;
    tests++; if (frame_cnt !== 16'd2) begin fails++; $display("FAIL bp_cnt_final: got %0d want 2", frame_cnt); end
  endtask

  task automatic test_short_frame();
    int e0;
    do_reset();
    m_ready = 1'b1;
    load_nominal();
    e0 = err_cnt;
    send_frame(11, 10);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL short_err: got %b want 1", err); end
    @(posedge clk); #1;
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL short_err_clear: got %b want 0", err); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL short_no_frame: m_valid %b want 0", m_valid); end
    tests++; if (err_cnt - e0 != 1) begin fails++; $display("FAIL short_err_count: %0d pulses want 1", err_cnt - e0); end
    send_frame(N, N - 1);
    @(posedge clk); #1;
    tests++; if (m_valid !== 1'b1 || m_data !== exp_nom) begin
      fails++; $display("FAIL short_next_frame: valid %b data %h want 1 %h", m_valid, m_data, exp_nom);
    end
    @(posedge clk); #1;
    tests++; if (frame_cnt !== 16'd1) begin fails++; $display("FAIL short_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_long_frame();
    int e0;
    do_reset();
    m_ready = 1'b1;
    load_nominal();
    e0 = err_cnt;
    for (int k = 0; k < N; k++) begin
      push(vec[k], 1'b0);
      if (k == N - 2) begin
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL long_err_early: got %b want 0 after sample 46", err); end
      end
    end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL long_err: got %b want 1 after sample 47", err); end
    for (int k = N; k < 60; k++) push(8'hFF, k == 59);
    repeat (3) @(posedge clk);
    #1;
    tests++; if (err_cnt - e0 != 1) begin fails++; $display("FAIL long_err_count: %0d pulses want 1", err_cnt - e0); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL long_no_frame: m_valid %b want 0", m_valid); end
    tests++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL long_cnt: got %0d want 0", frame_cnt); end
    send_frame(N, N - 1);
    @(posedge clk); #1;
    tests++; if (m_valid !== 1'b1 || m_data !== exp_nom) begin
      fails++; $display("FAIL long_next_frame: valid %b data %h want 1 %h", m_valid, m_data, exp_nom);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    m_ready = 1'b1;
    load_nominal();
    send_frame(N, N - 1);
    repeat (2) @(posedge clk);
    #1;
    m_ready = 1'b0;
    send_frame(N, N - 1);
    for (int k = 0; k < 20; k++) push(vec[k], 1'b0);
    tests++; if (m_valid !== 1'b1 || frame_cnt !== 16'd1) begin
      fails++; $display("FAIL mid_pre: valid %b cnt %0d want 1 1", m_valid, frame_cnt);
    end
    rst_n = 1'b0;
    #1;
    tests++; if (m_valid !== 1'b0)   begin fails++; $display("FAIL mid_m_valid: got %b want 0", m_valid); end
    tests++; if (m_data !== '0)      begin fails++; $display("FAIL mid_m_data: got %h want 0", m_data); end
    tests++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL mid_cnt: got %0d want 0", frame_cnt); end
    tests++; if (s_ready !== 1'b0)   begin fails++; $display("FAIL mid_s_ready: got %b want 0", s_ready); end
    tests++; if (err !== 1'b0)       begin fails++; $display("FAIL mid_err: got %b want 0", err); end
    @(posedge clk); #1 rst_n = 1'b1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    send_frame(N, N - 1);
    @(posedge clk); #1;
    tests++; if (m_valid !== 1'b1 || m_data !== exp_nom) begin
      fails++; $display("FAIL mid_next_frame: valid %b data %h want 1 %h", m_valid, m_data, exp_nom);
    end
    @(posedge clk); #1;
    tests++; if (frame_cnt !== 16'd1) begin fails++; $display("FAIL mid_next_cnt: got %0d want 1", frame_cnt); end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      exp_nom[2*k +: 2] = 2'(k % 4);
      exp_sat[2*k +: 2] = 2'd3;
    end
    test_reset();
    test_quant_sweep();
    test_nominal();
    test_back_to_back();
    test_backpressure();
    test_short_frame();
    test_long_frame();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
